// File: rtl/b16_boot_pkg.sv
// Shared definitions for the b16 boot loader: FSM states in frame order,
// default frame marker and small frame helpers.
package b16_boot_pkg;

    // Loader states; the header/data states are listed in the order their
    // bytes appear on the wire.
    typedef enum logic [3:0] {
        S_SYNC,
        S_ADDR_H,
        S_ADDR_L,
        S_LEN_H,
        S_LEN_L,
        S_DATA_H,
        S_DATA_L,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_e;

    // Frame start marker used unless the top is overridden
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Field that follows a single-step field on the wire
    function automatic state_e next_field(input state_e s);
        case (s)
            S_ADDR_H: return S_ADDR_L;
            S_ADDR_L: return S_LEN_H;
            S_LEN_H:  return S_LEN_L;
            S_DATA_H: return S_DATA_L;
            default:  return S_SYNC;
        endcase
    endfunction

    // Running 8-bit frame checksum
    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
        return sum + b;
    endfunction

endpackage

// File: rtl/boot_timeout.sv
// Saturating cycle counter: hit is raised in the cycle in which the
// TIMEOUT-th enabled cycle completes, so a state change on that edge lands
// exactly TIMEOUT enabled cycles after counting began.
module boot_timeout #(
    parameter int TIMEOUT = 1000000
) (
    input  logic clk,
    input  logic nreset,
    input  logic en,
    output logic hit
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Advance while enabled, stop at the last value
    always_comb begin
        count_d = count_q;
        if (en && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign hit = en && (count_q == LAST);

endmodule

// File: rtl/boot_loader.sv
// Boot loader: receives framed bytes, writes big-endian 16-bit words into
// the b16 boot RAM and releases the core once a frame checksums clean or
// no host has shown up within TIMEOUT cycles.
module boot_loader
    import b16_boot_pkg::*;
#(
    parameter int          AW        = 12,
    parameter int          TIMEOUT   = 1000000,
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic          ram_sel,
    output logic          ram_r,
    output logic [1:0]    ram_w,
    output logic [AW:1]   ram_addr,
    output logic [15:0]   ram_din,
    output logic          cpu_nreset,
    output logic          done,
    output logic          err
);

    state_e          state_q, state_d;
    logic [7:0]      hold_q, hold_d;      // high byte of the field being assembled
    logic [AW-1:0]   addr_q, addr_d;      // next RAM word address
    logic [15:0]     count_q, count_d;    // words still to write
    logic [7:0]      sum_q, sum_d;        // checksum of bytes after SYNC

    logic            rx_ready_q, rx_ready_d;
    logic            ram_sel_q, ram_sel_d;
    logic [AW-1:0]   ram_addr_q, ram_addr_d;
    logic [15:0]     ram_din_q, ram_din_d;
    logic            cpu_nreset_q, cpu_nreset_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            accept;
    logic            timer_en;
    logic            timeout_hit;

    assign accept = rx_valid && rx_ready_q;

    // SYNC is only ever occupied before the first sync byte (ERR re-syncs
    // straight into ADDR_H), so gating on the state disables the timer for good.
    assign timer_en = (state_q == S_SYNC);

    boot_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .nreset (nreset),
        .en     (timer_en),
        .hit    (timeout_hit)
    );

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        addr_d     = addr_q;
        count_d    = count_q;
        sum_d      = sum_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        err_d      = err_q;

        case (state_q)
            S_SYNC: begin
                if (accept && (rx_data == SYNC_BYTE)) begin
                    state_d = S_ADDR_H;
                    sum_d   = '0;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                    err_d   = 1'b0;
                end
            end
            S_ADDR_H, S_LEN_H, S_DATA_H: begin
                if (accept) begin
                    hold_d  = rx_data;
                    sum_d   = csum_add(sum_q, rx_data);
                    state_d = next_field(state_q);
                end
            end
            S_ADDR_L: begin
                if (accept) begin
                    addr_d  = AW'({hold_q, rx_data});
                    sum_d   = csum_add(sum_q, rx_data);
                    state_d = next_field(state_q);
                end
            end
            S_LEN_L: begin
                if (accept) begin
                    count_d = {hold_q, rx_data};
                    sum_d   = csum_add(sum_q, rx_data);
                    state_d = ({hold_q, rx_data} == 16'd0) ? S_CSUM : S_DATA_H;
                end
            end
            S_DATA_L: begin
                if (accept) begin
                    sum_d      = csum_add(sum_q, rx_data);
                    ram_addr_d = addr_q;
                    ram_din_d  = {hold_q, rx_data};
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: begin
                addr_d  = addr_q + 1'b1;
                count_d = count_q - 16'd1;
                state_d = (count_q == 16'd1) ? S_CSUM : S_DATA_H;
            end
            S_CSUM: begin
                if (accept) begin
                    sum_d = csum_add(sum_q, rx_data);
                    if (csum_add(sum_q, rx_data) == 8'd0) begin
                        state_d = S_DONE;
                        err_d   = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            S_ERR: begin
                if (accept && (rx_data == SYNC_BYTE)) begin
                    state_d = S_ADDR_H;
                    sum_d   = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_SYNC;
            end
        endcase

        // Outputs follow the state being entered so they are registered
        rx_ready_d   = !((state_d == S_WRITE) || (state_d == S_DONE));
        ram_sel_d    = (state_d == S_WRITE);
        cpu_nreset_d = (state_d == S_DONE);
        done_d       = (state_d == S_DONE);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q      <= S_SYNC;
            hold_q       <= '0;
            addr_q       <= '0;
            count_q      <= '0;
            sum_q        <= '0;
            rx_ready_q   <= 1'b0;
            ram_sel_q    <= 1'b0;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            cpu_nreset_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            addr_q       <= addr_d;
            count_q      <= count_d;
            sum_q        <= sum_d;
            rx_ready_q   <= rx_ready_d;
            ram_sel_q    <= ram_sel_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            cpu_nreset_q <= cpu_nreset_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    assign rx_ready   = rx_ready_q;
    assign ram_sel    = ram_sel_q;
    assign ram_r      = !ram_sel_q;
    assign ram_w      = {2{ram_sel_q}};
    assign ram_addr   = ram_addr_q;
    assign ram_din    = ram_din_q;
    assign cpu_nreset = cpu_nreset_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: frames are built by the bench,
// expected RAM writes go into a scoreboard queue and are popped as the DUT
// strobes the RAM port.
module tb_boot_loader;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        ram_sel;
    logic        ram_r;
    logic [1:0]  ram_w;
    logic [12:1] ram_addr;
    logic [15:0] ram_din;
    logic        cpu_nreset;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rel_cyc = 0;

    logic [27:0] exp_q[$];     // {addr[11:0], data[15:0]}
    logic [7:0]  frame_q[$];
    logic [15:0] words_q[$];

    always #5 clk = ~clk;

    boot_loader #(
        .AW        (12),
        .TIMEOUT   (100),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk        (clk),
        .nreset     (nreset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .ram_sel    (ram_sel),
        .ram_r      (ram_r),
        .ram_w      (ram_w),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .cpu_nreset (cpu_nreset),
        .done       (done),
        .err        (err)
    );

    // One clock; sample at the falling edge and pop the scoreboard on writes
    task automatic cycle();
        logic [27:0] e;
        @(negedge clk);
        cyc++;
        if (ram_sel === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%h din=%h, required no write", ram_addr, ram_din);
            end else begin
                e = exp_q.pop_front();
                if ({ram_addr, ram_din, ram_w, ram_r} !== {e, 2'b11, 1'b0}) begin
                    errors++;
                    $display("FAIL ram_write: got addr=%h din=%h w=%b r=%b, required addr=%h din=%h w=11 r=0",
                             ram_addr, ram_din, ram_w, ram_r, e[27:16], e[15:0]);
                end else begin
                    $display("write addr=%h din=%h", ram_addr, ram_din);
                end
            end
        end
    endtask

    // Present one byte after gap idle cycles and hold it until accepted
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit rdy;
        int n;
        rx_valid = 1'b0;
        repeat (gap) cycle();
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        do begin
            rdy = rx_ready;
            cycle();
            n++;
        end while (!rdy && n < 50);
        rx_valid = 1'b0;
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL byte_accept: byte %h not taken, rx_ready=%b required 1", b, rx_ready);
        end
    endtask

    // Build a frame from words_q and queue the writes it must cause
    task automatic build_frame(input logic [15:0] addr, input bit bad);
        logic [7:0]  s;
        logic [11:0] a;
        logic [15:0] len;
        len = 16'(words_q.size());
        frame_q.delete();
        frame_q.push_back(8'hA5);
        frame_q.push_back(addr[15:8]);
        frame_q.push_back(addr[7:0]);
        frame_q.push_back(len[15:8]);
        frame_q.push_back(len[7:0]);
        a = addr[11:0];
        foreach (words_q[i]) begin
            frame_q.push_back(words_q[i][15:8]);
            frame_q.push_back(words_q[i][7:0]);
            exp_q.push_back({a, words_q[i]});
            a = a + 12'd1;
        end
        s = 8'h00;
        for (int i = 1; i < frame_q.size(); i++) s = s + frame_q[i];
        s = 8'h00 - s;
        if (bad) s = s + 8'h01;
        frame_q.push_back(s);
    endtask

    // Send the built frame; core must still be held just before CSUM
    task automatic send_frame(input int gap);
        for (int i = 0; i < frame_q.size(); i++) begin
            if (i == frame_q.size() - 1) begin
                checks++;
                if ({cpu_nreset, done} !== 2'b00) begin
                    errors++;
                    $display("FAIL pre_release: cpu_nreset,done=%b required 00", {cpu_nreset, done});
                end
            end
            send_byte(frame_q[i], gap);
        end
        $display("frame sent: %0d bytes, csum=%h", frame_q.size(), frame_q[frame_q.size()-1]);
    endtask

    task automatic drain(input string name);
        repeat (3) cycle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_writes: %0d writes missing, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        @(negedge clk);
        nreset = 1'b0;
        repeat (2) cycle();
        nreset = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        repeat (2) cycle();
        checks++;
        if ({rx_ready, ram_sel, ram_r, ram_w, ram_addr, ram_din, cpu_nreset, done, err}
            !== {1'b0, 1'b0, 1'b1, 2'b00, 12'h000, 16'h0000, 3'b000}) begin
            errors++;
            $display("FAIL reset_values: rdy=%b sel=%b r=%b w=%b addr=%h din=%h cpu=%b done=%b err=%b, required 0 0 1 00 000 0000 0 0 0",
                     rx_ready, ram_sel, ram_r, ram_w, ram_addr, ram_din, cpu_nreset, done, err);
        end
        $display("test_reset done");
    endtask

    task automatic test_good_frame();
        do_reset();
        words_q = '{16'h1234, 16'h5678};
        build_frame(16'h0010, 1'b0);
        send_frame(0);
        checks++;
        if ({cpu_nreset, done, err, rx_ready} !== 4'b1100) begin
            errors++;
            $display("FAIL good_release: cpu,done,err,rdy=%b required 1100", {cpu_nreset, done, err, rx_ready});
        end
        drain("good");
        $display("test_good_frame done");
    endtask

    task automatic test_bad_then_good();
        do_reset();
        words_q = '{16'h1234, 16'h5678};
        build_frame(16'h0010, 1'b1);
        send_frame(0);
        checks++;
        if ({cpu_nreset, done, err, rx_ready} !== 4'b0011) begin
            errors++;
            $display("FAIL bad_csum: cpu,done,err,rdy=%b required 0011", {cpu_nreset, done, err, rx_ready});
        end
        drain("bad");
        // no timeout may apply while in ERR
        repeat (120) cycle();
        checks++;
        if ({cpu_nreset, done, err} !== 3'b001) begin
            errors++;
            $display("FAIL err_no_timeout: cpu,done,err=%b required 001", {cpu_nreset, done, err});
        end
        build_frame(16'h0010, 1'b0);
        send_byte(8'h3C, 0);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_garbage: err=%b required 1", err);
        end
        for (int i = 0; i < frame_q.size(); i++) begin
            send_byte(frame_q[i], 0);
            if (i == 0) begin
                checks++;
                if (err !== 1'b0) begin
                    errors++;
                    $display("FAIL err_clear_on_sync: err=%b required 0", err);
                end
            end
        end
        checks++;
        if ({cpu_nreset, done, err} !== 3'b110) begin
            errors++;
            $display("FAIL retry_release: cpu,done,err=%b required 110", {cpu_nreset, done, err});
        end
        drain("retry");
        $display("test_bad_then_good done");
    endtask

    task automatic test_timeout(input bit garbage);
        do_reset();
        if (garbage) begin
            send_byte(8'h00, 0);
            send_byte(8'hFF, 0);
        end
        while (cyc - rel_cyc < 99) cycle();
        checks++;
        if ({cpu_nreset, done} !== 2'b00) begin
            errors++;
            $display("FAIL timeout_early: cycle 99 cpu,done=%b required 00", {cpu_nreset, done});
        end
        cycle();
        checks++;
        if ({cpu_nreset, done, err, rx_ready} !== 4'b1100) begin
            errors++;
            $display("FAIL timeout_release: cycle 100 cpu,done,err,rdy=%b required 1100",
                     {cpu_nreset, done, err, rx_ready});
        end
        drain("timeout");
        $display("test_timeout garbage=%0d done", garbage);
    endtask

    task automatic test_wrap();
        do_reset();
        words_q = '{16'hAABB, 16'hCCDD};
        build_frame(16'h0FFF, 1'b0);
        send_frame(0);
        checks++;
        if ({cpu_nreset, done, err} !== 3'b110) begin
            errors++;
            $display("FAIL wrap_release: cpu,done,err=%b required 110", {cpu_nreset, done, err});
        end
        drain("wrap");
        $display("test_wrap done");
    endtask

    task automatic test_len_zero();
        do_reset();
        words_q.delete();
        build_frame(16'h0100, 1'b0);
        send_frame(0);
        checks++;
        if ({cpu_nreset, done, err} !== 3'b110) begin
            errors++;
            $display("FAIL len0_release: cpu,done,err=%b required 110", {cpu_nreset, done, err});
        end
        drain("len0");
        $display("test_len_zero done");
    endtask

    task automatic test_back_to_back_gaps();
        do_reset();
        words_q = '{16'h1234, 16'h5678};
        build_frame(16'h0010, 1'b0);
        send_frame(1);
        checks++;
        if ({cpu_nreset, done, err} !== 3'b110) begin
            errors++;
            $display("FAIL gapped_release: cpu,done,err=%b required 110", {cpu_nreset, done, err});
        end
        drain("gapped");
        $display("test_back_to_back_gaps done");
    endtask

    task automatic test_reset_midframe();
        do_reset();
        words_q = '{16'h1234, 16'h5678};
        build_frame(16'h0010, 1'b0);
        exp_q.delete();
        for (int i = 0; i < 6; i++) send_byte(frame_q[i], 0);
        nreset = 1'b0;
        #1;
        checks++;
        if ({rx_ready, ram_sel, ram_r, ram_w, ram_addr, ram_din, cpu_nreset, done, err}
            !== {1'b0, 1'b0, 1'b1, 2'b00, 12'h000, 16'h0000, 3'b000}) begin
            errors++;
            $display("FAIL midframe_reset: rdy=%b sel=%b r=%b w=%b addr=%h din=%h cpu=%b done=%b err=%b, required 0 0 1 00 000 0000 0 0 0",
                     rx_ready, ram_sel, ram_r, ram_w, ram_addr, ram_din, cpu_nreset, done, err);
        end
        rx_data  = 8'h34;
        rx_valid = 1'b1;
        repeat (3) cycle();
        rx_valid = 1'b0;
        nreset = 1'b1;
        rel_cyc = cyc;
        repeat (2) cycle();
        build_frame(16'h0010, 1'b0);
        send_frame(0);
        checks++;
        if ({cpu_nreset, done, err} !== 3'b110) begin
            errors++;
            $display("FAIL reload_release: cpu,done,err=%b required 110", {cpu_nreset, done, err});
        end
        drain("reload");
        $display("test_reset_midframe done");
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_then_good();
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_wrap();
        test_len_zero();
        test_back_to_back_gaps();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
